refill_ctrl: RTL and testbench
==============================

REFILL_CTRL -- requirements
Module: refill_ctrl

Interface
REQ-001 SHALL have parameter CACHE_LINE, default 128, line width in bits; only 128 is supported (4 words).
REQ-002 SHALL have parameter CACHE_SIZE, default 8192, cache capacity in bytes; index width IW = log2(CACHE_SIZE*8/CACHE_LINE) = 9; tag width TW = 32-IW-2 = 21.
REQ-003 SHALL have ports, in this order:
- HCLK  in  1  clock; all state updates on its rising edge.
- HRESETn  in  1  reset; synchronous, active-low.
- miss_req  in  1  refill request; sampled only in IDLE.
- miss_addr  in  32  missing address; split as {tag, index, offset[1:0], byte[1:0]}.
- busy  out  1  refill in progress.
- mem_req  out  1  memory word-read request.
- mem_addr  out  32  word address; bits [1:0] always 0.
- mem_ready  in  1  beat accepted; mem_rdata valid this cycle.
- mem_err  in  1  beat error; qualified by mem_req.
- mem_rdata  in  32  read data.
- line_we  out  1  one-cycle tag/data array write strobe.
- line_index  out  IW  array index.
- line_tag  out  TW  tag to store.
- line_data  out  128  assembled line; word k in bits [32k+31:32k].
- crit_valid  out  1  one-cycle strobe: requested word available.
- crit_word  out  32  requested word.
- fill_err  out  1  one-cycle strobe: refill aborted.

Function
REQ-004 SHALL implement FSM states IDLE, FETCH, WRITE.
REQ-005 In IDLE with miss_req=1, SHALL latch tag, index and offset from miss_addr, clear the beat counter, and enter FETCH on the next cycle.
REQ-006 In FETCH, SHALL hold mem_req=1 and mem_addr={tag,index,beat_off,2'b00}; mem_addr SHALL remain stable until mem_ready=1 or mem_err=1.
REQ-007 On a FETCH cycle with mem_ready=1 and mem_err=0, SHALL store mem_rdata into line word beat_off and increment the 2-bit beat counter.
REQ-008 After the 4th accepted beat, SHALL go to WRITE; WRITE SHALL last exactly one cycle with line_we=1, then return to IDLE.
REQ-009 line_index, line_tag and line_data SHALL be valid whenever line_we=1.
REQ-010 With mem_ready=1 on every beat, line_we SHALL assert exactly 5 cycles after the edge that samples miss_req.
REQ-011 mem_err=1 during FETCH SHALL pulse fill_err for one cycle, return to IDLE with no line_we, and discard the beat (mem_err has priority over mem_ready).
REQ-012 busy SHALL be 1 in FETCH and WRITE and 0 in IDLE; miss_req SHALL be ignored while busy=1.
REQ-013 crit_word SHALL equal the line word at the latched offset whenever crit_valid=1; crit_valid SHALL pulse exactly once per successful refill and never on an aborted one.
REQ-014 mem_req SHALL be 0 outside FETCH.

Reset
REQ-015 With HRESETn=0 at a clock edge, SHALL enter IDLE and drive busy, mem_req, line_we, crit_valid and fill_err to 0, and mem_addr, line_index, line_tag, line_data and crit_word to all-zeros.
REQ-016 Reset during FETCH or WRITE SHALL abort the refill with no line_we, crit_valid or fill_err pulse.

Configuration
REQ-017 With macro CRIT_WORD_FIRST_EN defined, beat_off SHALL be (offset+count) mod 4, and crit_valid SHALL pulse in the cycle after the first accepted beat.
REQ-018 Without CRIT_WORD_FIRST_EN, beat_off SHALL equal count (order 0,1,2,3), and crit_valid SHALL pulse in the WRITE cycle together with line_we.

Verification (memory model: word at addr A = (A>>2) - 0x280)
REQ-019 miss_addr=0x0000_0A10, mem_ready held 1 -> mem_addr sequence A10,A14,A18,A1C; line_we at cycle 5; line_index=0x0A1, line_tag=0, line_data=0x00000007_00000006_00000005_00000004.
REQ-020 CRIT_WORD_FIRST_EN defined, miss_addr=0x0000_0A18 -> mem_addr sequence A18,A1C,A10,A14; crit_valid one cycle after first beat with crit_word=6; line_data as in REQ-019.
REQ-021 mem_ready low for 3 cycles on beat 1 -> mem_addr held at A14 for those cycles; line_we at cycle 8; line_data unchanged from REQ-019.
REQ-022 mem_err=1 on beat 2 -> fill_err pulse; no line_we, no crit_valid (without macro); busy=0 next cycle; a new miss_req is then accepted.
REQ-023 HRESETn=0 mid-FETCH after 2 beats -> next cycle all outputs 0, state IDLE; second miss_req pulse while busy=1 produces no extra refill.

Source files
------------

// File: rtl/refill_ctrl.sv
// Cache line refill controller: fetches a 4-word line one word per beat, then writes it to the arrays.
// Optional macro CRIT_WORD_FIRST_EN: fetch starts at the missing word and crit_valid fires early.
module refill_ctrl #(
    parameter int CACHE_LINE = 128,
    parameter int CACHE_SIZE = 8192,
    localparam int IW = $clog2(CACHE_SIZE * 8 / CACHE_LINE),
    localparam int TW = 32 - IW - 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  miss_req,
    input  logic [31:0]           miss_addr,
    output logic                  busy,
    output logic                  mem_req,
    output logic [31:0]           mem_addr,
    input  logic                  mem_ready,
    input  logic                  mem_err,
    input  logic [31:0]           mem_rdata,
    output logic                  line_we,
    output logic [IW-1:0]         line_index,
    output logic [TW-1:0]         line_tag,
    output logic [CACHE_LINE-1:0] line_data,
    output logic                  crit_valid,
    output logic [31:0]           crit_word,
    output logic                  fill_err
);

    // Address tag field is narrower than the stored tag; the stored tag is zero-extended.
    localparam int TagLsb = IW + 4;
    localparam int AddrTw = 32 - TagLsb;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWrite
    } state_e;

    state_e                  state_q, state_d;
    logic [TW-1:0]           tag_q, tag_d;
    logic [IW-1:0]           index_q, index_d;
    logic [1:0]              off_q, off_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [CACHE_LINE-1:0]   line_q, line_d;
    logic [31:0]             crit_q, crit_d;
    logic                    fill_err_q, fill_err_d;
    logic                    crit_valid_q, crit_valid_d;
    logic [1:0]              beat_off;
    logic                    unused_byte;

    assign unused_byte = ^miss_addr[1:0];

`ifdef CRIT_WORD_FIRST_EN
    assign beat_off = off_q + cnt_q;
`else
    assign beat_off = cnt_q;
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q      <= StIdle;
            tag_q        <= '0;
            index_q      <= '0;
            off_q        <= '0;
            cnt_q        <= '0;
            line_q       <= '0;
            crit_q       <= '0;
            fill_err_q   <= 1'b0;
            crit_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            crit_q       <= crit_d;
            fill_err_q   <= fill_err_d;
            crit_valid_q <= crit_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        index_d      = index_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        crit_d       = crit_q;
        fill_err_d   = 1'b0;
        crit_valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (miss_req) begin
                    tag_d   = TW'(miss_addr[31:TagLsb]);
                    index_d = miss_addr[TagLsb-1:4];
                    off_d   = miss_addr[3:2];
                    cnt_d   = 2'd0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // An error beat is dropped even if mem_ready is also high.
                if (mem_err) begin
                    fill_err_d = 1'b1;
                    state_d    = StIdle;
                end else if (mem_ready) begin
                    line_d[{beat_off, 5'b00000} +: 32] = mem_rdata;
                    if (beat_off == off_q) begin
                        crit_d = mem_rdata;
                    end
`ifdef CRIT_WORD_FIRST_EN
                    if (cnt_q == 2'd0) begin
                        crit_valid_d = 1'b1;
                    end
`endif
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy       = (state_q != StIdle);
    assign mem_req    = (state_q == StFetch);
    assign mem_addr   = mem_req ? {tag_q[AddrTw-1:0], index_q, beat_off, 2'b00} : 32'h0;
    // Strobes are masked by reset so an aborted refill never emits a pulse.
    assign line_we    = (state_q == StWrite) && HRESETn;
    assign line_index = index_q;
    assign line_tag   = tag_q;
    assign line_data  = line_q;
    assign crit_word  = crit_q;
    assign fill_err   = fill_err_q && HRESETn;

`ifdef CRIT_WORD_FIRST_EN
    assign crit_valid = crit_valid_q && HRESETn;
`else
    logic unused_crit_valid;
    assign unused_crit_valid = crit_valid_q;
    assign crit_valid = line_we;
`endif

endmodule

// File: tb/tb_refill_ctrl.sv
// Scoreboard bench for refill_ctrl: stimulus pushes expected events, a negedge monitor pops them.
module tb_refill_ctrl;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         busy;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ready;
    logic         mem_err;
    logic [31:0]  mem_rdata;
    logic         line_we;
    logic [8:0]   line_index;
    logic [20:0]  line_tag;
    logic [127:0] line_data;
    logic         crit_valid;
    logic [31:0]  crit_word;
    logic         fill_err;

    refill_ctrl dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_err    (mem_err),
        .mem_rdata  (mem_rdata),
        .line_we    (line_we),
        .line_index (line_index),
        .line_tag   (line_tag),
        .line_data  (line_data),
        .crit_valid (crit_valid),
        .crit_word  (crit_word),
        .fill_err   (fill_err)
    );

    always #5 HCLK = ~HCLK;

    assign mem_rdata = (mem_addr >> 2) - 32'h280;

    typedef struct {
        int           cyc;
        logic [8:0]   idx;
        logic [20:0]  tag;
        logic [127:0] data;
    } line_t;

    typedef struct {
        int          cyc;
        logic [31:0] word;
    } crit_t;

    logic [31:0] addr_q[$];
    line_t       line_eq[$];
    crit_t       crit_eq[$];
    int          err_q[$];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    localparam logic [127:0] DataA = 128'h00000007_00000006_00000005_00000004;
    localparam logic [127:0] DataB = 128'h00000807_00000806_00000805_00000804;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every DUT-presented event is matched against the head of its queue.
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (mem_req) begin
                if (addr_q.size() == 0) begin
                    chk("mem_req_unexpected", {127'b0, mem_req}, 128'd0);
                end else if (mem_ready || mem_err) begin
                    chk("mem_addr", {96'b0, mem_addr}, {96'b0, addr_q.pop_front()});
                end else begin
                    chk("mem_addr_hold", {96'b0, mem_addr}, {96'b0, addr_q[0]});
                end
            end
            if (line_we) begin
                if (line_eq.size() == 0) begin
                    chk("line_we_unexpected", {127'b0, line_we}, 128'd0);
                end else begin
                    line_t e;
                    e = line_eq.pop_front();
                    chk("line_we_cycle", 128'(cyc), 128'(e.cyc));
                    chk("line_index", {119'b0, line_index}, {119'b0, e.idx});
                    chk("line_tag", {107'b0, line_tag}, {107'b0, e.tag});
                    chk("line_data", line_data, e.data);
                end
            end
            if (crit_valid) begin
                if (crit_eq.size() == 0) begin
                    chk("crit_valid_unexpected", {127'b0, crit_valid}, 128'd0);
                end else begin
                    crit_t c;
                    c = crit_eq.pop_front();
                    chk("crit_cycle", 128'(cyc), 128'(c.cyc));
                    chk("crit_word", {96'b0, crit_word}, {96'b0, c.word});
                end
            end
            if (fill_err) begin
                if (err_q.size() == 0) begin
                    chk("fill_err_unexpected", {127'b0, fill_err}, 128'd0);
                end else begin
                    chk("fill_err_cycle", 128'(cyc), 128'(err_q.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_miss(input logic [31:0] a);
        miss_req  = 1'b1;
        miss_addr = a;
        step();
        miss_req  = 1'b0;
    endtask

    task automatic drive(input logic [15:0] rdy, input logic [15:0] err, input int n);
        for (int i = 0; i < n; i++) begin
            mem_ready = rdy[i];
            mem_err   = err[i];
            step();
        end
        mem_ready = 1'b1;
        mem_err   = 1'b0;
    endtask

    task automatic push4(input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3);
        addr_q.push_back(a0);
        addr_q.push_back(a1);
        addr_q.push_back(a2);
        addr_q.push_back(a3);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, {127'b0, busy}, 128'd0);
        chk({tag, "_mem_req"}, {127'b0, mem_req}, 128'd0);
        chk({tag, "_line_we"}, {127'b0, line_we}, 128'd0);
        chk({tag, "_crit_valid"}, {127'b0, crit_valid}, 128'd0);
        chk({tag, "_fill_err"}, {127'b0, fill_err}, 128'd0);
        chk({tag, "_mem_addr"}, {96'b0, mem_addr}, 128'd0);
        chk({tag, "_line_index"}, {119'b0, line_index}, 128'd0);
        chk({tag, "_line_tag"}, {107'b0, line_tag}, 128'd0);
        chk({tag, "_line_data"}, line_data, 128'd0);
        chk({tag, "_crit_word"}, {96'b0, crit_word}, 128'd0);
    endtask

    // Full A10 refill with mem_ready always high, miss issued in cycle c.
    task automatic expect_a10(input int c);
        push4(32'hA10, 32'hA14, 32'hA18, 32'hA1C);
        line_eq.push_back('{c + 5, 9'h0A1, 21'h0, DataA});
`ifdef CRIT_WORD_FIRST_EN
        crit_eq.push_back('{c + 2, 32'd4});
`else
        crit_eq.push_back('{c + 5, 32'd4});
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        HRESETn   = 1'b0;
        miss_req  = 1'b0;
        miss_addr = 32'h0;
        mem_ready = 1'b1;
        mem_err   = 1'b0;
        idle(2);
        check_zero("reset");
        HRESETn = 1'b1;
        idle(2);

        // Basic refill, offset 0.
        c = cyc;
        expect_a10(c);
        start_miss(32'h0000_0A10);
        drive(16'hFFFF, 16'h0, 5);
        idle(2);

        // Offset 2: wrap order only when critical-word-first is built in.
        c = cyc;
`ifdef CRIT_WORD_FIRST_EN
        push4(32'hA18, 32'hA1C, 32'hA10, 32'hA14);
        crit_eq.push_back('{c + 2, 32'd6});
`else
        push4(32'hA10, 32'hA14, 32'hA18, 32'hA1C);
        crit_eq.push_back('{c + 5, 32'd6});
`endif
        line_eq.push_back('{c + 5, 9'h0A1, 21'h0, DataA});
        start_miss(32'h0000_0A18);
        drive(16'hFFFF, 16'h0, 5);
        idle(2);

        // Nonzero tag, offset 1.
        c = cyc;
`ifdef CRIT_WORD_FIRST_EN
        push4(32'h2A14, 32'h2A18, 32'h2A1C, 32'h2A10);
        crit_eq.push_back('{c + 2, 32'h805});
`else
        push4(32'h2A10, 32'h2A14, 32'h2A18, 32'h2A1C);
        crit_eq.push_back('{c + 5, 32'h805});
`endif
        line_eq.push_back('{c + 5, 9'h0A1, 21'h1, DataB});
        start_miss(32'h0000_2A14);
        drive(16'hFFFF, 16'h0, 5);
        idle(2);

        // Three-cycle stall on beat 1 stretches the refill to cycle 8.
        c = cyc;
        push4(32'hA10, 32'hA14, 32'hA18, 32'hA1C);
        line_eq.push_back('{c + 8, 9'h0A1, 21'h0, DataA});
`ifdef CRIT_WORD_FIRST_EN
        crit_eq.push_back('{c + 2, 32'd4});
`else
        crit_eq.push_back('{c + 8, 32'd4});
`endif
        start_miss(32'h0000_0A10);
        drive(16'b0000_0000_0111_0001, 16'h0, 8);
        idle(2);

        // Error on beat 2 (with mem_ready also high), then an immediate new miss.
        c = cyc;
        addr_q.push_back(32'hA10);
        addr_q.push_back(32'hA14);
        addr_q.push_back(32'hA18);
        err_q.push_back(c + 4);
`ifdef CRIT_WORD_FIRST_EN
        crit_eq.push_back('{c + 2, 32'd4});
`endif
        start_miss(32'h0000_0A10);
        drive(16'hFFFF, 16'h0004, 3);
        chk("busy_after_err", {127'b0, busy}, 128'd0);
        c = cyc;
        expect_a10(c);
        start_miss(32'h0000_0A10);
        drive(16'hFFFF, 16'h0, 5);
        idle(2);

        // Reset after two beats aborts the refill silently.
        c = cyc;
        addr_q.push_back(32'hA10);
        addr_q.push_back(32'hA14);
`ifdef CRIT_WORD_FIRST_EN
        crit_eq.push_back('{c + 2, 32'd4});
`endif
        start_miss(32'h0000_0A10);
        drive(16'hFFFF, 16'h0, 2);
        mem_ready = 1'b0;
        HRESETn   = 1'b0;
        step();
        HRESETn   = 1'b1;
        mem_ready = 1'b1;
        check_zero("midfetch_reset");
        idle(8);

        // A miss pulse while busy is ignored.
        c = cyc;
        expect_a10(c);
        start_miss(32'h0000_0A10);
        step();
        miss_req  = 1'b1;
        miss_addr = 32'h0000_1000;
        step();
        miss_req  = 1'b0;
        chk("busy_during_fetch", {127'b0, busy}, 128'd1);
        idle(12);
        chk("idle_after_refill", {127'b0, busy}, 128'd0);

        chk("addr_q_drained", 128'(addr_q.size()), 128'd0);
        chk("line_q_drained", 128'(line_eq.size()), 128'd0);
        chk("crit_q_drained", 128'(crit_eq.size()), 128'd0);
        chk("err_q_drained", 128'(err_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
